// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path.
//   - tx_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP).
//                  The encoding is fixed here so the receive side and any
//                  debug tooling decode it the same way.
//   - LINE_*     : serial line levels for the idle, start and stop conditions.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage : uart_tx_pkg

// File: rtl/uart_parity_gen.sv
// -----------------------------------------------------------------------------
// uart_parity_gen
// Combinational parity generator for the transmit frame.
//   Parameters:
//     DATA_WIDTH  payload width in bits
//   Ports:
//     data_i      latched payload
//     par_typ_i   0 = even parity, 1 = odd parity
//     parity_o    parity bit to place on the line
// The module body only exists when UART_TX_PARITY_EN is defined; without the
// macro the core never instantiates it and the file compiles to nothing.
// -----------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
module uart_parity_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  // Even parity makes the total count of ones (data + parity) even, so the
  // parity bit is simply the XOR of the data; odd parity inverts it.
  assign parity_o = (^data_i) ^ par_typ_i;

endmodule : uart_parity_gen
`endif

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Serial transmit engine: accepts a parallel word through a valid/busy
// handshake and sends one asynchronous frame
//   start(0) | DATA_WIDTH data bits, LSB first | [parity] | stop(1)
// Bit timing comes from a prescale down-counter on the system clock.
//
// Parameters:
//   DATA_WIDTH      payload bits per frame (>= 2)
//   PRESCALE_WIDTH  width of the prescale input
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (forces idle, truncates a frame)
//   p_data      word to transmit, latched on accept
//   data_valid  request; accepted only while busy is low
//   par_en      1 = insert a parity bit (latched on accept)
//   par_typ     0 = even, 1 = odd parity (latched on accept)
//   prescale    clocks per bit, 0 treated as 1 (latched on accept)
//   tx_out      registered serial line, idle high
//   busy        registered, high for exactly one frame length
//
// Build option:
//   UART_TX_PARITY_EN  when defined, the PARITY state and the parity
//                      generator are compiled in. When undefined, par_en and
//                      par_typ are accepted but ignored and every frame is
//                      DATA_WIDTH+2 bits long.
// -----------------------------------------------------------------------------
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1);
  localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  // Control state (reset)
  tx_state_e                 state_q, state_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  // Datapath state (not reset; only meaningful while a frame is running)
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;

  logic [PRESCALE_WIDTH-1:0] presc_eff;
  logic                      bit_end;

  // A prescale of zero would never terminate a bit, so it is promoted to 1.
  assign presc_eff = (prescale == '0) ? CNT_ONE : prescale;

  // The counter is loaded with the bit period and the bit ends on the cycle
  // it shows 1. The "<=" also covers a cleared counter defensively.
  assign bit_end = (cnt_q <= CNT_ONE);

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parity_bit;

  // Parity is taken from an unshifted copy of the word, since the shift
  // register has been consumed by the time the parity bit is due.
  uart_parity_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_gen (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .parity_o  (parity_bit)
  );
`else
  // Parity ports exist for interface compatibility only in this build.
  logic unused_par_inputs;
  assign unused_par_inputs = par_en ^ par_typ;
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    data_d    = data_q;
`endif

    // Every active state times its bit the same way: count down, reload on
    // the last cycle of the bit.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? presc_q : (cnt_q - CNT_ONE);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (data_valid) begin
          // Everything that shapes the frame is captured here so later input
          // changes cannot disturb it.
          state_d = ST_START;
          tx_d    = LINE_START;
          busy_d  = 1'b1;
          cnt_d   = presc_eff;
          presc_d = presc_eff;
          shreg_d = p_data;
`ifdef UART_TX_PARITY_EN
          par_en_d  = par_en;
          par_typ_d = par_typ;
          data_d    = p_data;
`endif
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          idx_d   = '0;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = parity_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = LINE_STOP;
            end
`else
            state_d = ST_STOP;
            tx_d    = LINE_STOP;
`endif
          end else begin
            // Bit 0 is already on the line; shift and present the next one.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
          // Index saturates at the last data bit.
          idx_d = (idx_q == IDX_LAST) ? idx_q : (idx_q + IDX_ONE);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = LINE_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          // Return to idle for at least one cycle before the next accept.
          state_d = ST_IDLE;
          tx_d    = LINE_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers: reset returns the line to idle immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  // Datapath registers: loaded on accept, no reset needed.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    data_q  <= data_d;
`endif
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Scoreboard bench for uart_tx_core. The stimulus process queues one expected
// frame description per accepted request; the monitor process pops a record
// when busy rises and checks every cycle of the frame plus the idle cycle
// after it. Expected line values come from the frame definition (start bit,
// LSB-first data, popcount parity, stop bit, each held max(prescale,1)
// cycles). Honours UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  typedef struct {
    logic [DW-1:0] d;
    bit            pe;
    bit            pt;
    int            p;
    int            trunc;  // 0 = full frame, else cycle index where reset shows
  } frame_t;

  frame_t exp_q[$];
  int     n_checks   = 0;
  int     n_fail     = 0;
  bit     mon_active = 1'b0;

  uart_tx_core #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Issue one request. Caller is positioned just after a rising edge.
  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt,
                      input int ps, input int trunc);
    frame_t f;
    int     guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: busy stuck at %b, expected 0", busy);
      return;
    end
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = PW'(ps);
    data_valid = 1'b1;
    f.d = d;
`ifdef UART_TX_PARITY_EN
    f.pe = pe;
`else
    f.pe = 1'b0;
`endif
    f.pt    = pt;
    f.p     = (ps == 0) ? 1 : ps;
    f.trunc = trunc;
    exp_q.push_back(f);
    @(posedge clk); #1;
    // Scramble inputs: the running frame must not notice.
    data_valid = 1'b0;
    p_data     = DW'($urandom);
    par_en     = 1'($urandom);
    par_typ    = 1'($urandom);
    prescale   = PW'($urandom);
    if (trunc > 0) begin
      repeat (trunc - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    frame_t f;
    bit     bits[$];
    int     n;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && rst === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: busy=1 with no request queued (t=%0t)", $time);
          for (int g = 0; g < 3000 && busy === 1'b1; g++) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          mon_active = 1'b1;
          bits = {};
          bits.push_back(1'b0);
          for (int i = 0; i < DW; i++) bits.push_back(f.d[i]);
          if (f.pe) bits.push_back((($countones(f.d) % 2) == 1) ^ f.pt);
          bits.push_back(1'b1);
          n = bits.size() * f.p;
          for (int c = 0; ; c++) begin
            if (f.trunc != 0 && c == f.trunc) begin
              chk($sformatf("rst_tx d=%02h", f.d), 32'(tx_out), 32'd1);
              chk($sformatf("rst_busy d=%02h", f.d), 32'(busy), 32'd0);
              break;
            end
            if (c == n) begin
              chk($sformatf("gap_busy d=%02h len=%0d", f.d, n), 32'(busy), 32'd0);
              chk($sformatf("gap_tx d=%02h", f.d), 32'(tx_out), 32'd1);
              break;
            end
            chk($sformatf("tx d=%02h p=%0d cyc=%0d", f.d, f.p, c),
                32'(tx_out), 32'(bits[c / f.p]));
            chk($sformatf("busy d=%02h cyc=%0d", f.d, c), 32'(busy), 32'd1);
            @(negedge clk);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    rst        = 1'b1;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xA5 with even parity, 4 clocks per bit
    send(8'hA5, 1'b1, 1'b0, 4, 0);
    // 0x01 even then odd parity
    send(8'h01, 1'b1, 1'b0, 4, 0);
    send(8'h01, 1'b1, 1'b1, 4, 0);
    // prescale 1, no parity, back-to-back, then prescale 0 behaving as 1
    send(8'hFF, 1'b0, 1'b0, 1, 0);
    send(8'hFF, 1'b0, 1'b0, 1, 0);
    send(8'hFF, 1'b0, 1'b0, 0, 0);
    send(8'h5A, 1'b1, 1'b1, 0, 0);

    // Request during DATA of a running frame must be dropped
    send(8'h5A, 1'b0, 1'b0, 4, 0);
    repeat (14) @(posedge clk);
    #1;
    p_data     = 8'h3C;
    data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 data_valid = 1'b0;

    // Reset in the middle of data bit 3 (cycle 17 at 4 clocks/bit), then a
    // clean frame
    send(8'hC3, 1'b0, 1'b0, 4, 18);
    send(8'h81, 1'b0, 1'b0, 4, 0);

    // Random frames with random idle gaps
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(DW'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5), 0);
    end

    guard = 0;
    while ((exp_q.size() != 0 || mon_active || busy !== 1'b0) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d frames still pending", exp_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_tx", 32'(tx_out), 32'd1);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_core
